// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the GMII receive/transmit frame logic.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int TUSER_W         = 3;
  localparam int TUSER_CRC_BIT   = 0;
  localparam int TUSER_RUNT_BIT  = 1;
  localparam int TUSER_GIANT_BIT = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} rx_state_t;

  typedef struct packed {
    logic [7:0]         tdata;
    logic               tvalid;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;
  } axis_beat_t;
endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC32 (no final inversion).
module crc32_d8 import eth_pkg::*; (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    crc_o = c;
  end
endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive framer: preamble/SFD hunt, optional FCS strip via a delay line,
// CRC/length checking and saturating good/bad frame counters.
module gmii_rx_frame_ctrl import eth_pkg::*; #(
  parameter int GMII_WIDTH = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int STRIP_FCS  = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  gmii_rx_en_i,
  input  logic [GMII_WIDTH-1:0] gmii_rxd_i,
  output logic [7:0]            m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [TUSER_W-1:0]    m_axis_tuser_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);
  localparam int DEPTH = (STRIP_FCS != 0) ? 5 : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

  rx_state_t             state_q, state_d;
  logic [31:0]           crc_q, crc_d, crc_nxt;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DEPTH-1:0][7:0] dl_q, dl_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  logic                  accept, eof, has_beat;
  logic [TUSER_W-1:0]    flags;
  axis_beat_t            beat;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd_i[7:0]),
    .crc_o  (crc_nxt)
  );

  assign accept   = (state_q == ST_DATA) && gmii_rx_en_i;
  assign eof      = (state_q == ST_DATA) && !gmii_rx_en_i;
  // The line holds DEPTH bytes once len reaches DEPTH; below that nothing is emitted.
  assign has_beat = (len_q >= DEPTH_L);

  always_comb begin
    flags                  = '0;
    flags[TUSER_CRC_BIT]   = (crc_q != CRC32_RESIDUE);
    flags[TUSER_RUNT_BIT]  = (len_q < MIN_L);
    flags[TUSER_GIANT_BIT] = (len_q > MAX_L);
  end

  always_comb begin
    beat        = '0;
    beat.tvalid = (accept || eof) && has_beat;
    beat.tlast  = eof && has_beat;
    beat.tdata  = beat.tvalid ? dl_q[DEPTH-1] : 8'h00;
    beat.tuser  = beat.tlast ? flags : '0;
  end

  assign m_axis_tdata_o  = beat.tdata;
  assign m_axis_tvalid_o = beat.tvalid;
  assign m_axis_tlast_o  = beat.tlast;
  assign m_axis_tuser_o  = beat.tuser;
  assign frame_cnt_o     = frame_cnt_q;
  assign err_cnt_o       = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    dl_d        = dl_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_en_i)
          state_d = (gmii_rxd_i[7:0] == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_en_i) begin
          state_d = ST_IDLE;
        end else if (gmii_rxd_i[7:0] == SFD_BYTE) begin
          state_d = ST_DATA;
          crc_d   = CRC32_INIT;
          len_d   = '0;
        end else if (gmii_rxd_i[7:0] != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (gmii_rx_en_i) begin
          crc_d = crc_nxt;
          if (len_q != LEN_SAT) len_d = len_q + 1'b1;
          dl_d[0] = gmii_rxd_i[7:0];
          for (int i = 1; i < DEPTH; i++) dl_d[i] = dl_q[i-1];
        end else begin
          state_d = ST_IDLE;
          // A frame too short to yield a beat counts as bad regardless of its flags.
          if (!has_beat || (flags != '0)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end else begin
            if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!gmii_rx_en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC32_INIT;
      len_q       <= '0;
      dl_q        <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      dl_q        <= dl_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed bench for gmii_rx_frame_ctrl with STRIP_FCS=1 (payload bytes are 0,1,2,...).
module tb_gmii_rx_frame_ctrl;
  logic        clk = 1'b0;
  logic        arstn;
  logic        rx_en;
  logic [7:0]  rxd;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
  logic [2:0]  tuser;
  logic [31:0] frame_cnt, err_cnt;

  int total = 0;
  int bad   = 0;

  gmii_rx_frame_ctrl dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .gmii_rx_en_i    (rx_en),
    .gmii_rxd_i      (rxd),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tlast_o  (tlast),
    .m_axis_tuser_o  (tuser),
    .frame_cnt_o     (frame_cnt),
    .err_cnt_o       (err_cnt)
  );

  always #5 clk = ~clk;

  // Beat monitor: per-frame length, tuser and last byte; data must follow 0,1,2,...
  int         cur = 0;
  int         dat_err = 0;
  int         len_q[$];
  logic [2:0] usr_q[$];
  logic [7:0] lst_q[$];

  always @(negedge clk or negedge arstn) begin
    if (!arstn) cur = 0;
    else if (tvalid) begin
      if (tdata !== 8'(cur)) dat_err++;
      if (!tlast && tuser !== 3'b000) dat_err++;
      cur++;
      if (tlast) begin
        len_q.push_back(cur);
        usr_q.push_back(tuser);
        lst_q.push_back(tdata);
        cur = 0;
      end
    end else if (tlast !== 1'b0 || tuser !== 3'b000) dat_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  logic [7:0] frm[$];

  // fcs_mode: 0 = no FCS, 1 = correct FCS, 2 = FCS with last byte bit 0 flipped
  task automatic build(input int n_pay, input int fcs_mode);
    logic [31:0] c;
    logic [31:0] fcs;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      frm.push_back(8'(i));
      c = crc_step(c, 8'(i));
    end
    fcs = ~c;
    if (fcs_mode != 0) begin
      for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
      if (fcs_mode == 2) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    end
  endtask

  task automatic drive(input logic en, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_en = en;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  // Preamble + SFD + frm, then one rx_en-low cycle; optional async reset at data byte rst_at.
  task automatic send(input int rst_at);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i]);
      if (i == rst_at) begin
        #1;
        chk("rst_pre_tvalid", 32'(tvalid), 32'd1);
        arstn = 1'b0;
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        arstn = 1'b1;
      end
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic chk_frame(input string tag, input int len, input logic [2:0] usr, input logic [7:0] lst);
    if (len_q.size() > 0) begin
      chk({tag, "_len"}, 32'(len_q.pop_front()), 32'(len));
      chk({tag, "_tuser"}, 32'(usr_q.pop_front()), 32'(usr));
      chk({tag, "_last"}, 32'(lst_q.pop_front()), 32'(lst));
    end
  endtask

  initial begin
    arstn = 1'b0;
    rx_en = 1'b0;
    rxd   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tlast", 32'(tlast), 32'd0);
    chk("reset_frame_cnt", frame_cnt, 32'd0);
    chk("reset_err_cnt", err_cnt, 32'd0);
    arstn = 1'b1;
    idle(2);

    // good 64-byte frame
    build(60, 1); send(-1); idle(1);
    chk("good_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("good", 60, 3'b000, 8'h3B);
    chk("good_frame_cnt", frame_cnt, 32'd1);
    chk("good_err_cnt", err_cnt, 32'd0);

    // corrupted FCS
    build(60, 2); send(-1); idle(1);
    chk("crc_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("crc", 60, 3'b001, 8'h3B);
    chk("crc_frame_cnt", frame_cnt, 32'd1);
    chk("crc_err_cnt", err_cnt, 32'd1);

    // runt: 40 bytes including valid FCS
    build(36, 1); send(-1); idle(1);
    chk("runt_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("runt", 36, 3'b010, 8'h23);
    chk("runt_err_cnt", err_cnt, 32'd2);

    // bad preamble, one idle cycle, then a good frame
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h5D);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h10 + i));
    drive(1'b0, 8'h00);
    build(60, 1); send(-1); idle(1);
    chk("badpre_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("badpre_next", 60, 3'b000, 8'h3B);
    chk("badpre_frame_cnt", frame_cnt, 32'd2);
    chk("badpre_err_cnt", err_cnt, 32'd2);

    // two good frames with 12-cycle gap, then a 3-byte frame after a 1-cycle gap
    build(60, 1); send(-1); idle(11);
    send(-1);
    build(3, 0); send(-1); idle(1);
    chk("b2b_nfrm", 32'(len_q.size()), 32'd2);
    chk_frame("b2b_a", 60, 3'b000, 8'h3B);
    chk_frame("b2b_b", 60, 3'b000, 8'h3B);
    chk("b2b_frame_cnt", frame_cnt, 32'd4);
    chk("b2b_err_cnt", err_cnt, 32'd3);

    // async reset at data byte 20, remainder of the frame must be dropped
    build(60, 1); send(20); idle(1);
    chk("rst_nfrm", 32'(len_q.size()), 32'd0);
    chk("rst_post_frame_cnt", frame_cnt, 32'd0);
    chk("rst_post_err_cnt", err_cnt, 32'd0);
    send(-1); idle(1);
    chk("rst_next_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("rst_next", 60, 3'b000, 8'h3B);
    chk("rst_next_frame_cnt", frame_cnt, 32'd1);

    // MIN_LEN-1 is a runt
    build(59, 1); send(-1); idle(1);
    chk("min1_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("min1", 59, 3'b010, 8'h3A);
    chk("min1_err_cnt", err_cnt, 32'd1);

    // exactly MAX_LEN is good
    build(1514, 1); send(-1); idle(1);
    chk("max_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("max", 1514, 3'b000, 8'hE9);
    chk("max_frame_cnt", frame_cnt, 32'd2);

    // MAX_LEN+1 is a giant but still forwarded
    build(1515, 1); send(-1); idle(1);
    chk("giant_nfrm", 32'(len_q.size()), 32'd1);
    chk_frame("giant", 1515, 3'b100, 8'hEA);
    chk("giant_frame_cnt", frame_cnt, 32'd2);
    chk("giant_err_cnt", err_cnt, 32'd2);

    chk("data_stream", 32'(dat_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
